data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Wait-stated data-memory responder for the MEM stage: serves loads/stores from a local word array.
// Optional MEM_STATS_EN adds saturating rd_count/wr_count outputs for completed good accesses.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err
`ifdef MEM_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
`endif
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [31:0] BASE  = 32'(BASE_ADDR);
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD =
      CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [31:0]       mem_q [DEPTH_WORDS];

   logic              req_c;
   logic [31:0]       off_c;
   logic              bad_c;
   logic [IDX_W-1:0]  idx_c;
   logic              complete_c;
   logic              mem_we_c;

   // Address decode; addresses below BASE wrap high and fall out of range.
   assign req_c = mem_r_en | mem_w_en;
   assign off_c = addr - BASE;
   assign bad_c = (addr[1:0] != 2'b00) || (off_c >= SPAN);
   assign idx_c = off_c[IDX_W+1:2];

   // Next-state, wait counter and completion-edge data capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      complete_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_c) begin
               if (WAIT_CYCLES == 0) begin
                  state_d    = S_DONE;
                  complete_c = 1'b1;
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         S_BUSY: begin
            if (!req_c) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d    = S_DONE;
               complete_c = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (complete_c) begin
         err_d = bad_c;
         if (mem_w_en) begin
            if (mem_r_en) rdata_d = '0;
         end else begin
            rdata_d = bad_c ? '0 : mem_q[idx_c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array contents survive reset; a held reset still blocks the zero-wait write path.
   assign mem_we_c = complete_c & mem_w_en & ~bad_c & ~rst;

   always_ff @(posedge clk) begin
      if (mem_we_c) mem_q[idx_c] <= wdata;
   end

   assign rdata = rdata_q;
   assign err   = err_q;
   assign ready = ((state_q == S_IDLE) && !req_c) || (state_q == S_DONE);

`ifdef MEM_STATS_EN
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;

   // Saturating counts of completed, error-free accesses.
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (complete_c && !bad_c) begin
         if (mem_w_en) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
         end else begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=3 instance and a zero-wait instance.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        r_en, w_en;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        ready, err;
   logic        r0_en, w0_en;
   logic [31:0] addr0, wdata0;
   logic [31:0] rdata0;
   logic        ready0, err0;
`ifdef MEM_STATS_EN
   logic [15:0] rd_cnt, wr_cnt, rd_cnt0, wr_cnt0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(1024), .WAIT_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
`ifdef MEM_STATS_EN
      , .rd_count(rd_cnt), .wr_count(wr_cnt)
`endif
   );

   data_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .mem_r_en(r0_en), .mem_w_en(w0_en), .addr(addr0),
      .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0)
`ifdef MEM_STATS_EN
      , .rd_count(rd_cnt0), .wr_count(wr_cnt0)
`endif
   );

   // Starts at posedge+1; cyc = cycle index of the first ready, -1 if it never came.
   task automatic run_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int cyc, output logic [31:0] rd, output logic e);
      r_en = r; w_en = w; addr = a; wdata = d;
      cyc = -1; rd = 'x; e = 1'bx;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ready) begin
            cyc = k; rd = rdata; e = err;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic run_txn0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int cyc, output logic [31:0] rd, output logic e);
      r0_en = r; w0_en = w; addr0 = a; wdata0 = d;
      cyc = -1; rd = 'x; e = 1'bx;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ready0) begin
            cyc = k; rd = rdata0; e = err0;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic go_idle();
      r_en = 1'b0; w_en = 1'b0; r0_en = 1'b0; w0_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      r_en = 0; w_en = 0; addr = 0; wdata = 0;
      r0_en = 0; w0_en = 0; addr0 = 0; wdata0 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
      checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b expected 1", ready0); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 0", rdata0); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int cyc; logic [31:0] rd; logic e;
      run_txn(0, 1, 32'd1024, 32'hDEADBEEF, cyc, rd, e);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL basic_wr_latency: got %0d expected 4", cyc); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_wr_err: got %b expected 0", e); end
      r_en = 0; w_en = 0;
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready: got %b expected 1", ready); end
      @(posedge clk); #1;
      run_txn(1, 0, 32'd1024, 32'h0, cyc, rd, e);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL basic_rd_latency: got %0d expected 4", cyc); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_rd_err: got %b expected 0", e); end
      go_idle();
   endtask

   task automatic test_back_to_back();
      int cyc; logic [31:0] rd; logic e;
      run_txn(0, 1, 32'd1028, 32'd5, cyc, rd, e);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_wr_latency: got %0d expected 4", cyc); end
      run_txn(1, 0, 32'd1028, 32'h0, cyc, rd, e);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_rd1_latency: got %0d expected 4", cyc); end
      checks++; if (rd !== 32'd5) begin errors++; $display("FAIL b2b_rd1_data: got %h expected 5", rd); end
      run_txn(1, 0, 32'd1028, 32'h0, cyc, rd, e);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_rd2_latency: got %0d expected 4", cyc); end
      checks++; if (rd !== 32'd5) begin errors++; $display("FAIL b2b_rd2_data: got %h expected 5", rd); end
      go_idle();
   endtask

   task automatic test_errors();
      int cyc; logic [31:0] rd; logic e;
      run_txn(1, 0, 32'd1026, 32'h0, cyc, rd, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_misaligned: got %b expected 1", e); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_misaligned_rdata: got %h expected 0", rd); end
      run_txn(0, 1, 32'd1280, 32'h0BADF00D, cyc, rd, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_range: got %b expected 1", e); end
      run_txn(1, 0, 32'd1024, 32'h0, cyc, rd, e);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL err_array_kept: got %h expected deadbeef", rd); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_good_rd: got %b expected 0", e); end
      run_txn(1, 0, 32'd1020, 32'h0, cyc, rd, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_below_base: got %b expected 1", e); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_below_base_rdata: got %h expected 0", rd); end
      run_txn(0, 1, 32'd1276, 32'h600DCAFE, cyc, rd, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_last_word_wr: got %b expected 0", e); end
      run_txn(1, 0, 32'd1276, 32'h0, cyc, rd, e);
      checks++; if (rd !== 32'h600DCAFE) begin errors++; $display("FAIL err_last_word_rd: got %h expected 600dcafe", rd); end
      r_en = 0; w_en = 0;
      @(negedge clk);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", err); end
      @(posedge clk); #1;
   endtask

   task automatic test_both_and_zero_wait();
      int cyc; logic [31:0] rd; logic e;
      run_txn(1, 0, 32'd1024, 32'h0, cyc, rd, e);
      run_txn(1, 1, 32'd1032, 32'd7, cyc, rd, e);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL both_rdata: got %h expected 0", rd); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL both_err: got %b expected 0", e); end
      run_txn(1, 0, 32'd1032, 32'h0, cyc, rd, e);
      checks++; if (rd !== 32'd7) begin errors++; $display("FAIL both_written: got %h expected 7", rd); end
      go_idle();
      run_txn0(0, 1, 32'd1036, 32'h1234, cyc, rd, e);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL zw_wr_latency: got %0d expected 1", cyc); end
      run_txn0(1, 0, 32'd1036, 32'h0, cyc, rd, e);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL zw_rd_latency: got %0d expected 1", cyc); end
      checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL zw_rd_data: got %h expected 1234", rd); end
      run_txn0(1, 0, 32'd1025, 32'h0, cyc, rd, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL zw_err: got %b expected 1", e); end
      go_idle();
   endtask

   task automatic test_abort();
      int cyc; logic [31:0] rd; logic e;
      run_txn(0, 1, 32'd1040, 32'h1111, cyc, rd, e);
      go_idle();
      r_en = 0; w_en = 1; addr = 32'd1040; wdata = 32'hAAAA;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_busy_ready: got %b expected 0", ready); end
      @(posedge clk); #1;
      w_en = 0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_idle_ready: got %b expected 1", ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b expected 0", err); end
      @(posedge clk); #1;
      run_txn(1, 0, 32'd1040, 32'h0, cyc, rd, e);
      checks++; if (rd !== 32'h1111) begin errors++; $display("FAIL abort_no_write: got %h expected 1111", rd); end
      go_idle();
   endtask

   task automatic test_reset_mid();
      int cyc; logic [31:0] rd; logic e;
      run_txn(0, 1, 32'd1044, 32'h2222, cyc, rd, e);
      run_txn(1, 0, 32'd1044, 32'h0, cyc, rd, e);
      go_idle();
      r_en = 0; w_en = 1; addr = 32'd1044; wdata = 32'hBBBB;
      repeat (2) begin @(posedge clk); #1; end
      #1 rst = 1'b1;
      #1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_req: got %b expected 0", ready); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h expected 0", rdata); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", err); end
      @(posedge clk); #1;
      w_en = 0;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_idle: got %b expected 1", ready); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run_txn(1, 0, 32'd1044, 32'h0, cyc, rd, e);
      checks++; if (rd !== 32'h2222) begin errors++; $display("FAIL rstmid_old_data: got %h expected 2222", rd); end
      go_idle();
   endtask

`ifdef MEM_STATS_EN
   task automatic test_stats();
      int cyc; logic [31:0] rd; logic e;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL stats_rd_reset: got %0d expected 0", rd_cnt); end
      @(posedge clk); #1;
      run_txn(1, 0, 32'd1024, 32'h0, cyc, rd, e);
      run_txn(1, 0, 32'd1028, 32'h0, cyc, rd, e);
      run_txn(0, 1, 32'd1048, 32'h3, cyc, rd, e);
      run_txn(1, 0, 32'd1026, 32'h0, cyc, rd, e);
      go_idle();
      checks++; if (rd_cnt !== 16'd2) begin errors++; $display("FAIL stats_rd: got %0d expected 2", rd_cnt); end
      checks++; if (wr_cnt !== 16'd1) begin errors++; $display("FAIL stats_wr: got %0d expected 1", wr_cnt); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_errors();
      test_both_and_zero_wait();
      test_abort();
      test_reset_mid();
`ifdef MEM_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
